// File: rtl/win_detector.sv
// win_detector: scans the four lines through a newly placed stone for a run of five
module win_detector #(
    parameter int N = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [6:0]     pos,
    input  logic           color,
    input  logic [N*N-1:0] board_black,
    input  logic [N*N-1:0] board_white,
    output logic           busy,
    output logic           done,
    output logic           win,
    output logic           win_color,
    output logic [1:0]     win_dir,
    output logic [3:0]     run_len,
    output logic           err
);
    localparam int IW = $clog2(N*N);
    localparam logic [7:0] CELLS = 8'(N*N);
    localparam logic signed [9:0] NS = 10'(N);

    typedef enum logic [1:0] {IDLE, SCAN_POS, SCAN_NEG, DONE} state_t;

    state_t state, state_n;
    logic [6:0] pos_q;
    logic color_q, chk, chk_n;
    logic [N*N-1:0] blk_q, wht_q;
    logic [1:0] dir, dir_n, win_dir_n;
    logic [2:0] count, count_n, offset, offset_n;
    logic [3:0] run_len_n;
    logic win_n, win_color_n, err_n;
    logic signed [9:0] row, col, dr, dc, off_s, nr, nc;
    logic [IW-1:0] idx;
    logic inb, match, valid;

    assign row   = 10'(pos_q / 7'(N));
    assign col   = 10'(pos_q % 7'(N));
    assign off_s = 10'(offset);
    assign dr    = {9'b0, dir != 2'd0};
    assign dc    = dir == 2'd1 ? 10'sd0 : dir == 2'd3 ? -10'sd1 : 10'sd1;
    assign nr    = state == SCAN_NEG ? row - off_s * dr : row + off_s * dr;
    assign nc    = state == SCAN_NEG ? col - off_s * dc : col + off_s * dc;
    assign inb   = nr >= 10'sd0 && nr < NS && nc >= 10'sd0 && nc < NS;
    assign idx   = IW'(nr * NS + nc);
    assign match = inb && (color_q ? wht_q[idx] : blk_q[idx]);
    // The placed stone is validated against the snapshot during the first scan cycle
    assign valid = {1'b0, pos_q} < CELLS && (color_q ? wht_q[IW'(pos_q)] : blk_q[IW'(pos_q)]);
    assign busy  = state != IDLE;
    assign done  = state == DONE;

    // Next-state, counter and result logic of the scan FSM
    always_comb begin
        state_n     = state;
        dir_n       = dir;
        count_n     = count;
        offset_n    = offset;
        chk_n       = 1'b0;
        win_n       = win;
        win_color_n = win_color;
        win_dir_n   = win_dir;
        run_len_n   = run_len;
        err_n       = err;
        case (state)
            IDLE: if (start) begin
                state_n     = SCAN_POS;
                dir_n       = 2'd0;
                count_n     = 3'd1;
                offset_n    = 3'd1;
                chk_n       = 1'b1;
                win_n       = 1'b0;
                win_color_n = 1'b0;
                win_dir_n   = 2'd0;
                run_len_n   = 4'd0;
                err_n       = 1'b0;
            end
            SCAN_POS, SCAN_NEG:
                if (chk && !valid) begin
                    state_n = DONE;
                    err_n   = 1'b1;
                end else if (match && count == 3'd4) begin
                    state_n   = DONE;
                    count_n   = 3'd5;
                    win_n     = 1'b1;
                    win_dir_n = dir;
                    run_len_n = 4'd5;
                end else if (match && offset != 3'd4) begin
                    count_n  = count + 3'd1;
                    offset_n = offset + 3'd1;
                end else begin
                    count_n  = count + 3'(match);
                    offset_n = 3'd1;
                    if (state == SCAN_POS) state_n = SCAN_NEG;
                    else if (dir == 2'd3) state_n = DONE;
                    else begin
                        state_n = SCAN_POS;
                        dir_n   = dir + 2'd1;
                        count_n = 3'd1;
                    end
                end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (state_n == DONE && state != DONE) win_color_n = color_q;
    end

    // State, snapshot and result registers; rst aborts any check in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dir       <= 2'd0;
            count     <= 3'd0;
            offset    <= 3'd0;
            chk       <= 1'b0;
            pos_q     <= 7'd0;
            color_q   <= 1'b0;
            blk_q     <= '0;
            wht_q     <= '0;
            win       <= 1'b0;
            win_color <= 1'b0;
            win_dir   <= 2'd0;
            run_len   <= 4'd0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            dir       <= dir_n;
            count     <= count_n;
            offset    <= offset_n;
            chk       <= chk_n;
            win       <= win_n;
            win_color <= win_color_n;
            win_dir   <= win_dir_n;
            run_len   <= run_len_n;
            err       <= err_n;
            if (state == IDLE && start) begin
                pos_q   <= pos;
                color_q <= color;
                blk_q   <= board_black;
                wht_q   <= board_white;
            end
        end
    end
endmodule

// File: tb/tb_win_detector.sv
// tb_win_detector: vector table plus scoreboard of expected check results
module tb_win_detector;
    localparam int N = 10;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, color = 1'b0;
    logic [6:0] pos = 7'd0;
    logic [N*N-1:0] board_black = '0, board_white = '0;
    logic busy, done, win, win_color, err;
    logic [1:0] win_dir;
    logic [3:0] run_len;

    win_detector #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .pos(pos), .color(color),
        .board_black(board_black), .board_white(board_white),
        .busy(busy), .done(done), .win(win), .win_color(win_color),
        .win_dir(win_dir), .run_len(run_len), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*N-1:0] bb, bw;
        logic [6:0] p;
        logic c, ew, ee;
        logic [1:0] ed;
        logic [3:0] el;
        int lat;
    } vec_t;

    typedef struct {
        logic ew, ee, ec;
        logic [1:0] ed;
        logic [3:0] el;
        int cyc;
        int tag;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    vec_t vt[11];
    int cyc = 0, passed = 0, total = 0, done_seen = 0, exp_dones = 0, d0 = 0;

    function automatic logic [N*N-1:0] line(input int s, input int st, input int n);
        logic [N*N-1:0] b;
        b = '0;
        for (int i = 0; i < n; i++) b[s + i * st] = 1'b1;
        return b;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act == expv) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        #1;
        if (done) begin
            done_seen <= done_seen + 1;
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                check($sformatf("done_cycle[%0d]", mon_e.tag), cyc, mon_e.cyc);
                check($sformatf("win[%0d]", mon_e.tag), win, mon_e.ew);
                check($sformatf("err[%0d]", mon_e.tag), err, mon_e.ee);
                check($sformatf("win_dir[%0d]", mon_e.tag), win_dir, mon_e.ed);
                check($sformatf("run_len[%0d]", mon_e.tag), run_len, mon_e.el);
                check($sformatf("win_color[%0d]", mon_e.tag), win_color, mon_e.ec);
            end
        end
    end

    task automatic issue(input vec_t v, input int tag);
        @(negedge clk);
        board_black = v.bb;
        board_white = v.bw;
        pos = v.p;
        color = v.c;
        start = 1'b1;
        q.push_back('{ew: v.ew, ee: v.ee, ec: v.c, ed: v.ed, el: v.el, cyc: cyc + v.lat, tag: tag});
        exp_dones++;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input int tag);
        for (int i = 0; i < 60 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            check($sformatf("timeout[%0d]", tag), q.size(), 0);
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{line(44, 1, 1), '0, 7'd44, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 9};
        vt[1]  = '{line(40, 1, 5), '0, 7'd40, 1'b0, 1'b1, 1'b0, 2'd0, 4'd5, 5};
        vt[2]  = '{line(8, 1, 5), '0, 7'd10, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 11};
        vt[3]  = '{'0, line(4, 9, 5), 7'd22, 1'b1, 1'b1, 1'b0, 2'd3, 4'd5, 12};
        vt[4]  = '{'0, '0, 7'd100, 1'b1, 1'b0, 1'b1, 2'd0, 4'd0, 2};
        vt[5]  = '{'0, '0, 7'd44, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0, 2};
        vt[6]  = '{line(5, 10, 5), '0, 7'd25, 1'b0, 1'b1, 1'b0, 2'd1, 4'd5, 8};
        vt[7]  = '{'0, line(0, 11, 6), 7'd0, 1'b1, 1'b1, 1'b0, 2'd2, 4'd5, 9};
        vt[8]  = '{line(44, 1, 1), '0, 7'd44, 1'b1, 1'b0, 1'b1, 2'd0, 4'd0, 2};
        vt[9]  = '{line(40, 1, 4), line(44, 1, 1), 7'd41, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 12};
        vt[10] = '{line(95, 1, 5), '0, 7'd99, 1'b0, 1'b1, 1'b0, 2'd0, 4'd5, 6};

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_win", win, 0);
        check("rst_win_color", win_color, 0);
        check("rst_win_dir", win_dir, 0);
        check("rst_run_len", run_len, 0);
        check("rst_err", err, 0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            issue(vt[i], i);
            wait_idle(i);
        end

        issue(vt[1], 20);
        wait_idle(20);
        repeat (3) @(negedge clk);
        check("hold_win", win, 1);
        check("hold_run_len", run_len, 5);
        issue(vt[0], 21);
        check("accept_clears_win", win, 0);
        check("accept_clears_run_len", run_len, 0);
        check("accept_busy", busy, 1);
        wait_idle(21);

        issue(vt[0], 22);
        repeat (2) @(negedge clk);
        board_black = vt[1].bb;
        pos = 7'd40;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(22);

        issue(vt[1], 23);
        board_black = '0;
        wait_idle(23);

        @(negedge clk);
        board_black = vt[3].bb;
        board_white = vt[3].bw;
        pos = vt[3].p;
        color = vt[3].c;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        d0 = done_seen;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_done", done_seen - d0, 0);
        issue(vt[3], 24);
        wait_idle(24);

        @(negedge clk);
        board_black = vt[1].bb;
        pos = vt[1].p;
        color = 1'b0;
        start = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_over_start_busy", busy, 0);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        d0 = done_seen;
        repeat (10) @(negedge clk);
        check("rst_over_start_no_done", done_seen - d0, 0);

        check("done_count", done_seen, exp_dones);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
